// File: rtl/inst_fetch_buf_pkg.sv
// Shared types and defaults for the instruction prefetch buffer.
// Word helpers keep address alignment in one place.
package inst_fetch_buf_pkg;

   localparam int unsigned FB_DEPTH   = 4;
   localparam int unsigned FB_MAX_OUT = 4;
   localparam int unsigned XLEN       = 32;

   typedef logic [XLEN-1:0] word_t;

   localparam word_t ZERO_WORD = '0;

   typedef struct packed {
      logic  vld;
      logic  stale;
      word_t addr;
   } mem_req_t;

   function automatic word_t word_align(input word_t a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

   function automatic word_t next_word(input word_t a);
      return word_align(a) + word_t'(4);
   endfunction

endpackage

// File: rtl/inst_fetch_buf_fifo.sv
// In-order instruction storage with flush; head word is always
// presented on rdata_o, writes become visible the following cycle.
module fetch_fifo
   import inst_fetch_buf_pkg::*;
#(
   parameter int unsigned DEPTH = FB_DEPTH,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          push_i,
   input  word_t         wdata_i,
   input  logic          pop_i,
   output word_t         rdata_o,
   output logic [CW-1:0] cnt_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   word_t          mem_q [DEPTH];
   logic [PW-1:0]  wr_q, wr_d;
   logic [PW-1:0]  rd_q, rd_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (push_i) wr_d = inc(wr_q);
         if (pop_i)  rd_d = inc(rd_q);
         cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_q];
   assign cnt_o   = cnt_q;

endmodule

// File: rtl/inst_fetch_buf.sv
// Sequential instruction prefetcher between the IF stage and a
// pipelined req/gnt/rvalid instruction memory.
module inst_fetch_buf
   import inst_fetch_buf_pkg::*;
#(
   parameter int unsigned DEPTH   = FB_DEPTH,
   parameter int unsigned MAX_OUT = FB_MAX_OUT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        core_ce_i,
   input  logic [31:0] core_addr_i,
   input  logic        hold_i,
   output logic [31:0] core_inst_o,
   output logic        stallreq_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   word_t          head_q, head_d;
   word_t          fetch_q, fetch_d;
   logic [2:0]     out_q, out_d;
   logic [2:0]     drop_q, drop_d;
   mem_req_t       req_q, req_d;

   logic [CW-1:0]  occ;
   word_t          head_data;
   logic           same_pc, hit, redirect;
   logic           gnt, rv, rv_drop, push, pop;
   logic [7:0]     live;
   logic           can_issue;

   assign same_pc  = core_addr_i[31:2] == head_q[31:2];
   assign hit      = core_ce_i & (occ != '0) & same_pc;
   assign redirect = core_ce_i & ~same_pc;
   assign gnt      = req_q.vld & mem_gnt_i;
   assign rv       = mem_rvalid_i & (out_q != 3'd0);
   assign rv_drop  = rv & (drop_q != 3'd0);
   assign push     = rv & ~rv_drop & ~redirect;
   assign pop      = hit & ~hold_i;

   // Live = buffered words plus responses that will land in the buffer,
   // counting a non-stale request granted this cycle for lookahead issue.
   assign live = 8'(occ) + 8'(out_q) - 8'(drop_q)
               + 8'(gnt & ~req_q.stale);

   assign can_issue = core_ce_i & ~redirect
                    & (~req_q.vld | gnt)
                    & (live < 8'(DEPTH))
                    & ((4'(out_q) + 4'(gnt)) < 4'(MAX_OUT));

   always_comb begin
      head_d  = head_q;
      fetch_d = fetch_q;
      req_d   = req_q;
      out_d   = out_q + 3'(gnt) - 3'(rv);
      drop_d  = drop_q - 3'(rv_drop) + 3'(gnt & req_q.stale);
      if (gnt) begin
         req_d.vld   = 1'b0;
         req_d.stale = 1'b0;
      end
      if (pop) head_d = next_word(head_q);
      if (redirect) begin
         head_d  = word_align(core_addr_i);
         fetch_d = word_align(core_addr_i);
         drop_d  = out_d;
         if (req_q.vld && !gnt) req_d.stale = 1'b1;
      end
      if (can_issue) begin
         req_d.vld   = 1'b1;
         req_d.stale = 1'b0;
         req_d.addr  = fetch_q;
         fetch_d     = next_word(fetch_q);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         fetch_q <= '0;
         out_q   <= '0;
         drop_q  <= '0;
         req_q   <= '0;
      end else begin
         head_q  <= head_d;
         fetch_q <= fetch_d;
         out_q   <= out_d;
         drop_q  <= drop_d;
         req_q   <= req_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redirect),
      .push_i  (push),
      .wdata_i (mem_rdata_i),
      .pop_i   (pop),
      .rdata_o (head_data),
      .cnt_o   (occ)
   );

   assign core_inst_o = hit ? head_data : ZERO_WORD;
   assign stallreq_o  = rst & core_ce_i & ~hit;
   assign mem_req_o   = req_q.vld;
   assign mem_addr_o  = req_q.addr;

   a_rv_has_outstanding: assert property (
      @(posedge clk) disable iff (!rst)
      mem_rvalid_i |-> (out_q != 3'd0)
   );

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed bench for inst_fetch_buf with an in-order
// pipelined memory model of configurable latency.
module tb_inst_fetch_buf;
   import inst_fetch_buf_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_ce_i;
   logic [31:0] core_addr_i;
   logic        hold_i;
   logic [31:0] core_inst_o;
   logic        stallreq_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   typedef struct {
      logic [31:0] start;
      int          lat;
      int          n;
      logic [31:0] exp_first;
      logic [31:0] exp_last;
      bit          nostall;
   } row_t;

   pend_t       q[$];
   row_t        rows[4];
   int          lat = 1;
   int          cyc_n = 0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] pc;

   inst_fetch_buf dut (
      .clk          (clk),
      .rst          (rst),
      .core_ce_i    (core_ce_i),
      .core_addr_i  (core_addr_i),
      .hold_i       (hold_i),
      .core_inst_o  (core_inst_o),
      .stallreq_o   (stallreq_o),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i)
   );

   always #5 clk = ~clk;

   // Memory image: each word is its own address tagged in the top half.
   function automatic logic [31:0] f(input logic [31:0] a);
      return {a[31:2], 2'b00} ^ 32'hDEAD_0000;
   endfunction

   task automatic chk(input string name,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic settle();
      #1;
      if (core_ce_i && rst) begin
         if (!stallreq_o)
            chk("hit_data", core_inst_o, f(core_addr_i));
         else
            chk("miss_nop", core_inst_o, 32'h0);
      end
   endtask

   task automatic tick();
      logic        acc;
      logic [31:0] a;
      pend_t       p;
      acc = mem_req_o & mem_gnt_i;
      a   = mem_addr_o;
      @(posedge clk);
      cyc_n++;
      #1;
      if (acc) begin
         p.addr = a;
         p.due  = cyc_n - 1 + lat;
         q.push_back(p);
      end
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
      if (q.size() != 0 && q[0].due <= cyc_n) begin
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = f(q[0].addr);
         void'(q.pop_front());
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      q.delete();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      rst   = 1'b1;
      cyc_n = 0;
   endtask

   task automatic run_stream(input  logic [31:0] start,
                             input  int          n,
                             input  int          budget,
                             output logic [31:0] first,
                             output logic [31:0] last,
                             output int          first_cyc,
                             output int          stalls,
                             output bit          to);
      int k;
      int cy;
      k = 0;
      cy = 0;
      pc = start;
      first = 32'h0;
      last = 32'h0;
      first_cyc = -1;
      stalls = 0;
      to = 1'b0;
      while (k < n) begin
         if (cy >= budget) begin
            to = 1'b1;
            break;
         end
         core_ce_i   = 1'b1;
         core_addr_i = pc;
         hold_i      = 1'b0;
         settle();
         if (!stallreq_o) begin
            if (k == 0) begin
               first = core_inst_o;
               first_cyc = cy;
            end
            last = core_inst_o;
            k++;
            pc = pc + 32'd4;
         end else if (k > 0) begin
            stalls++;
         end
         tick();
         cy++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] fw, lw;
      int          fc, st;
      bit          to;

      rows[0] = '{32'h0000_0200, 2, 6, 32'hDEAD_0200, 32'hDEAD_0214, 1'b0};
      rows[1] = '{32'h0000_1000, 3, 5, 32'hDEAD_1000, 32'hDEAD_1010, 1'b0};
      rows[2] = '{32'h0000_0000, 1, 8, 32'hDEAD_0000, 32'hDEAD_001C, 1'b0};
      rows[3] = '{32'hFFFF_FFF8, 1, 4, 32'h2152_FFF8, 32'hDEAD_0004, 1'b1};

      rst          = 1'b0;
      core_ce_i    = 1'b1;
      core_addr_i  = 32'h40;
      hold_i       = 1'b0;
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
      #2;
      chk("rst_inst", core_inst_o, 32'h0);
      chk("rst_stall", 32'(stallreq_o), 32'h0);
      chk("rst_req", 32'(mem_req_o), 32'h0);
      chk("rst_addr", mem_addr_o, 32'h0);

      // Cold start, latency 1, gnt always high
      do_reset();
      lat = 1;
      mem_gnt_i = 1'b1;
      run_stream(32'h0, 8, 20, fw, lw, fc, st, to);
      chk("t1_timeout", 32'(to), 32'h0);
      chk("t1_first", fw, 32'hDEAD_0000);
      chk("t1_last", lw, 32'hDEAD_001C);
      chk("t1_first_by_c4", 32'(fc >= 0 && fc <= 4), 32'h1);
      chk("t1_stalls", 32'(st), 32'h0);

      for (int i = 0; i < 4; i++) begin
         lat = rows[i].lat;
         run_stream(rows[i].start, rows[i].n, 40, fw, lw, fc, st, to);
         chk($sformatf("row%0d_timeout", i), 32'(to), 32'h0);
         chk($sformatf("row%0d_first", i), fw, rows[i].exp_first);
         chk($sformatf("row%0d_last", i), lw, rows[i].exp_last);
         if (rows[i].nostall)
            chk($sformatf("row%0d_stalls", i), 32'(st), 32'h0);
      end

      // Grant withheld: request must hold steady
      do_reset();
      lat = 1;
      mem_gnt_i = 1'b0;
      core_ce_i = 1'b1;
      core_addr_i = 32'h40;
      repeat (2) begin
         settle();
         tick();
      end
      repeat (5) begin
         settle();
         chk("t2_req", 32'(mem_req_o), 32'h1);
         chk("t2_addr", mem_addr_o, 32'h40);
         chk("t2_stall", 32'(stallreq_o), 32'h1);
         tick();
      end
      mem_gnt_i = 1'b1;
      run_stream(32'h40, 4, 20, fw, lw, fc, st, to);
      chk("t2_timeout", 32'(to), 32'h0);
      chk("t2_first", fw, 32'hDEAD_0040);

      // Buffer fills under hold, then drains without stalls
      hold_i = 1'b1;
      core_addr_i = pc;
      repeat (8) begin
         settle();
         tick();
      end
      repeat (10) begin
         settle();
         chk("t3_no_req", 32'(mem_req_o), 32'h0);
         chk("t3_inst", core_inst_o, 32'hDEAD_0050);
         chk("t3_stall", 32'(stallreq_o), 32'h0);
         tick();
      end
      run_stream(pc, 4, 4, fw, lw, fc, st, to);
      chk("t3_drain_timeout", 32'(to), 32'h0);
      chk("t3_drain_first_cyc", 32'(fc), 32'h0);
      chk("t3_drain_last", lw, 32'hDEAD_005C);

      // Redirect with three requests in flight
      do_reset();
      lat = 3;
      mem_gnt_i = 1'b1;
      core_addr_i = 32'h0;
      repeat (3) begin
         settle();
         tick();
      end
      run_stream(32'h100, 3, 20, fw, lw, fc, st, to);
      chk("t4_timeout", 32'(to), 32'h0);
      chk("t4_first", fw, 32'hDEAD_0100);
      chk("t4_last", lw, 32'hDEAD_0108);
      chk("t4_latency", 32'(fc >= 0 && fc <= 6), 32'h1);

      // Redirect while the old request waits for grant
      do_reset();
      lat = 1;
      mem_gnt_i = 1'b0;
      core_addr_i = 32'h0;
      settle();
      tick();
      core_addr_i = 32'h100;
      settle();
      chk("t5_pending", 32'(mem_req_o), 32'h1);
      tick();
      mem_gnt_i = 1'b1;
      settle();
      chk("t5_old_req", 32'(mem_req_o), 32'h1);
      chk("t5_old_addr", mem_addr_o, 32'h0);
      tick();
      settle();
      chk("t5_new_req", 32'(mem_req_o), 32'h1);
      chk("t5_new_addr", mem_addr_o, 32'h100);
      tick();
      run_stream(32'h100, 2, 10, fw, lw, fc, st, to);
      chk("t5_timeout", 32'(to), 32'h0);
      chk("t5_first", fw, 32'hDEAD_0100);

      // Asynchronous reset mid-stream
      do_reset();
      lat = 2;
      mem_gnt_i = 1'b1;
      core_addr_i = 32'h0;
      repeat (4) begin
         settle();
         tick();
      end
      settle();
      rst = 1'b0;
      #1;
      chk("t6_inst", core_inst_o, 32'h0);
      chk("t6_stall", 32'(stallreq_o), 32'h0);
      chk("t6_req", 32'(mem_req_o), 32'h0);
      chk("t6_addr", mem_addr_o, 32'h0);
      do_reset();
      run_stream(32'h0, 4, 20, fw, lw, fc, st, to);
      chk("t6_timeout", 32'(to), 32'h0);
      chk("t6_first", fw, 32'hDEAD_0000);
      chk("t6_last", lw, 32'hDEAD_000C);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
